dmem_reader: RTL and testbench

DMEM_READER -- requirements
Module: dmem_reader

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_rsp_fifo.sv | 72 +++++++
 rtl/dmem_reader.sv | 113 +++++++++++
 tb/tb_dmem_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: defaults and shared types for the dmem_reader read path.
package dmem_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 32;

  // One buffered response word at the default data width.
  typedef logic [DEF_DATA_W-1:0] rsp_entry_t;

  // Pointer width for a power-of-two buffer depth (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// dmem_rsp_fifo: response buffer for dmem_reader. Power-of-two depth, so the
// read and write pointers wrap by natural overflow. Storage is not reset.
module dmem_rsp_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = rsp_entry_t,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;
  entry_t           store_q [DEPTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_en  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign count   = count_q;
  assign head    = store_q[rptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    wptr_d  = wptr_q + PTR_W'(push_en);
    rptr_d  = rptr_q + PTR_W'(pop_en);
    if (push_en && !pop_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the write pointer.
  always_ff @(posedge clock) begin
    // NOTE: data storage has no reset; the occupancy count alone decides which entries are meaningful.
    if (push_en) begin
      store_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_reader.sv
// dmem_reader: issues word reads to a synchronous data memory (one-cycle read
// latency, no read enable) and buffers the returned words in request order.
// Optional write-to-read forwarding is enabled by defining DMEM_READER_FWD_EN:
// a store to the read address in the accept cycle supplies the response word,
// since the memory returns the pre-store value in that case.
module dmem_reader
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned CNT_W = ptr_width(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("dmem_reader: DEPTH must be a power of two and at least 2");
  end

  logic              accept;
  logic              in_flight_q, in_flight_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [CNT_W:0]    occupancy;

  // Ready depends only on registered occupancy, never on rsp_ready, so a
  // word in flight always has a free slot waiting for it.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight_q};
  assign req_ready = (occupancy < (CNT_W + 1)'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign mem_addr  = accept ? req_addr : addr_q;

  assign in_flight_d = accept;
  assign addr_d      = accept ? req_addr : addr_q;

  // In-flight flag and last accepted address.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      addr_q      <= addr_d;
    end
  end

`ifdef DMEM_READER_FWD_EN
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  assign fwd_hit_d  = accept ? (wr_en && (wr_addr == req_addr)) : fwd_hit_q;
  assign fwd_data_d = accept ? wr_data : fwd_data_q;

  // Forward flag, captured alongside each accepted address.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_hit_q <= 1'b0;
    end else begin
      fwd_hit_q <= fwd_hit_d;
    end
  end

  // Forwarded store data; only meaningful while the flag is set.
  always_ff @(posedge clock) begin
    fwd_data_q <= fwd_data_d;
  end

  assign push_data = fwd_hit_q ? fwd_data_q : mem_q;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign push_data = mem_q;
`endif

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = in_flight_q || !fifo_empty;

  dmem_rsp_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(logic [DATA_W-1:0])
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_flight_q),
    .push_data(push_data),
    .pop      (pop),
    .head     (rsp_data),
    .count    (fifo_count),
    .full     (fifo_full_unused),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_dmem_reader.sv
// tb_dmem_reader: self-checking bench for dmem_reader (default parameters).
// A transaction-level model (pending word + FIFO queue of response words)
// predicts the outputs every cycle; directed literal checks pin the model.
module tb_dmem_reader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
`ifdef DMEM_READER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  always #5 clk = ~clk;

  dmem_reader dut (
    .clock    (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .mem_addr (mem_addr),
    .mem_q    (mem_q),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory: read-first synchronous RAM, one-cycle read latency.
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always @(posedge clk) begin
    mem_q <= mem[mem_addr];
    if (wr_en) mem[wr_addr] = wr_data;
  end

  // Behavioural model: at most one word in flight, then a FIFO of words.
  logic [DATA_W-1:0] buf_q [$];
  bit                pend_valid = 1'b0;
  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] last_addr  = '0;
  logic [DATA_W-1:0] cand_data;
  logic [DATA_W-1:0] popped [$];

  function automatic bit model_ready();
    return (buf_q.size() + (pend_valid ? 1 : 0)) < DEPTH;
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      buf_q.delete();
      pend_valid = 1'b0;
      last_addr  = '0;
    end else begin
      acc = req_valid && model_ready();
      if (buf_q.size() != 0 && rsp_ready) void'(buf_q.pop_front());
      if (pend_valid) buf_q.push_back(pend_data);
      pend_valid = acc;
      if (acc) begin
        pend_data = cand_data;
        last_addr = req_addr;
      end
    end
  end

  // Compare process: outputs are checked mid-cycle, after inputs settle.
  always @(negedge clk) begin
    bit exp_ready;
    #2;
    // Word the memory (or a same-cycle store, when forwarding) supplies if accepted now.
    cand_data = (FWD && wr_en && (wr_addr == req_addr)) ? wr_data : mem[req_addr];
    if (!reset) begin
      exp_ready = model_ready();
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, buf_q.size() != 0);
      check("busy", busy, pend_valid || buf_q.size() != 0);
      if (buf_q.size() != 0) check("rsp_data", rsp_data, buf_q[0]);
      check("mem_addr", mem_addr, (req_valid && exp_ready) ? req_addr : last_addr);
      if (rsp_valid && rsp_ready) popped.push_back(rsp_data);
    end
  end

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a);
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    wr_en     = 1'b0;
  endtask

  // Hold a request until accepted, within a bounded number of cycles.
  task automatic send(input logic [ADDR_W-1:0] a);
    int waited = 0;
    drive(1'b1, a);
    #1;
    while (!req_ready && waited < 20) begin
      drive(1'b1, a);
      #1;
      waited++;
    end
    if (waited >= 20) check("accept_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    mem[12'h004] = 32'hDEADBEEF;
    mem[12'h010] = 32'h000000A0;
    mem[12'h011] = 32'h000000A1;
    mem[12'h012] = 32'h000000A2;
    mem[12'h020] = 32'h00000001;
    mem[12'h030] = 32'h000000B0;
    mem[12'h031] = 32'h000000B1;
    repeat (2) @(negedge clk);

    // Post-reset state, then a single read with two-cycle latency.
    reset = 1'b0;
    #3;
    check("post_reset_rsp_valid", rsp_valid, 1'b0);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_req_ready", req_ready, 1'b1);
    drive(1'b1, 12'h004);
    drive(1'b0, '0);
    drive(1'b0, '0);
    #3;
    check("single_read_valid", rsp_valid, 1'b1);
    check("single_read_data", rsp_data, 32'hDEADBEEF);

    // Back-to-back reads drained in order.
    send(12'h010);
    send(12'h011);
    send(12'h012);
    repeat (6) drive(1'b0, '0);
    n = popped.size();
    if (n >= 3) begin
      check("b2b_0", popped[n-3], 32'hA0);
      check("b2b_1", popped[n-2], 32'hA1);
      check("b2b_2", popped[n-1], 32'hA2);
    end else begin
      check("b2b_count", n, 3);
    end

    // Back-pressure: buffer fills, ready drops, one pop frees a slot.
    rsp_ready = 1'b0;
    drive(1'b1, 12'h030);
    drive(1'b1, 12'h031);
    drive(1'b0, '0);
    #3;
    check("full_ready_a", req_ready, 1'b0);
    drive(1'b0, '0);
    rsp_ready = 1'b1;
    #3;
    check("full_ready_b", req_ready, 1'b0);
    check("full_head", rsp_data, 32'hB0);
    drive(1'b0, '0);
    rsp_ready = 1'b0;
    #3;
    check("after_pop_ready", req_ready, 1'b1);
    check("after_pop_head", rsp_data, 32'hB1);
    rsp_ready = 1'b1;
    repeat (3) drive(1'b0, '0);

    // Read with a same-cycle store to the same address.
    drive(1'b1, 12'h020);
    wr_en = 1'b1; wr_addr = 12'h020; wr_data = 32'h5;
    drive(1'b0, '0);
    drive(1'b0, '0);
    #3;
    check("fwd_valid", rsp_valid, 1'b1);
    check("fwd_data", rsp_data, FWD ? 32'h5 : 32'h1);
    repeat (2) drive(1'b0, '0);

    // Reset one cycle after an accept discards the read.
    drive(1'b1, 12'h040);
    drive(1'b0, '0);
    reset = 1'b1;
    drive(1'b0, '0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1'b0, '0);
      #3;
      check("rst_no_rsp", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", req_ready, 1'b1);
    end

    // Randomized traffic: a streaming phase then random back-pressure and stores.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_valid = (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      req_addr  = 12'h100 + 12'($urandom_range(0, 7));
      rsp_ready = (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 12'h100 + 12'($urandom_range(0, 7));
      wr_data   = $urandom;
    end
    rsp_ready = 1'b1;
    repeat (6) drive(1'b0, '0);
    #3;
    check("final_idle_busy", busy, 1'b0);
    check("final_idle_valid", rsp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
